// File: rtl/fir_zo_pkg.sv
// Shared definitions for the zero/one-coefficient FIR coefficient loader.
//
// Contents:
//   DEF_NTAPS, DEF_DW, DEF_CW, DEF_NUMW : default filter geometry
//   COEF_ZERO/POS/NEG/ILL              : 2-bit ternary coefficient codes
//   loader_state_t                     : loader FSM states
package fir_zo_pkg;

  localparam int DEF_NTAPS = 10;
  localparam int DEF_DW    = 8;
  localparam int DEF_CW    = 2;
  localparam int DEF_NUMW  = 4;

  localparam logic [DEF_CW-1:0] COEF_ZERO = 2'b00;
  localparam logic [DEF_CW-1:0] COEF_POS  = 2'b01;
  localparam logic [DEF_CW-1:0] COEF_NEG  = 2'b11;
  localparam logic [DEF_CW-1:0] COEF_ILL  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } loader_state_t;

endpackage

// File: rtl/zo_tap_counter.sv
// Tap index counter shared by the LOAD and FLUSH phases of the loader.
//
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   clear : synchronous clear to 0 (priority over en)
//   en    : count enable
//   count : current tap index, NUMW bits
//   tc    : terminal count, high while count == NTAPS-1
module zo_tap_counter
  import fir_zo_pkg::*;
#(
  parameter int NUMW  = DEF_NUMW,
  parameter int NTAPS = DEF_NTAPS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            en,
  output logic [NUMW-1:0] count,
  output logic            tc
);

  localparam logic [NUMW-1:0] LAST = NUMW'(NTAPS - 1);

  assign tc = (count == LAST);

  // Saturates at the terminal count so the index can never run past the
  // last tap, even if the enable is left high for an extra cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fir_zo_coef_loader.sv
// Coefficient loader in front of the zero/one-coefficient FIR.
// Accepts a packed coefficient word over a req/ack handshake, writes it into
// the filter one tap per cycle, flushes the delay line with zero samples and
// then passes the live sample stream through. Live samples never reach the
// filter while coefficients are being changed.
//
// Optional feature macro: COEF_CHECK_EN
//   defined   : a word containing the illegal code 10 is rejected with
//               load_ack + err, no writes, state unchanged
//   undefined : no check, err stays 0
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load_req   : host load request (held until load_ack)
//   coef_bus   : packed coefficients, tap k at [CW*k+CW-1 : CW*k]
//   load_ack   : one-cycle pulse, coef_bus captured (or rejected)
//   sample_in  : live sample stream
//   fir_in     : sample driven to the filter
//   Coef_num   : tap index being written
//   Coef_Val   : coefficient code being written
//   Coef_w_en  : coefficient write strobe
//   busy       : high while writing or flushing
//   done       : one-cycle pulse on the first RUN cycle
//   err        : one-cycle pulse on a rejected load
//
// All outputs are registered; each output reflects what the FSM did in the
// state it occupied during the previous cycle.
module fir_zo_coef_loader
  import fir_zo_pkg::*;
#(
  parameter int NTAPS = DEF_NTAPS,
  parameter int DW    = DEF_DW,
  parameter int CW    = DEF_CW,
  parameter int NUMW  = DEF_NUMW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_req,
  input  logic [NTAPS*CW-1:0] coef_bus,
  output logic                load_ack,
  input  logic [DW-1:0]       sample_in,
  output logic [DW-1:0]       fir_in,
  output logic [NUMW-1:0]     Coef_num,
  output logic [CW-1:0]       Coef_Val,
  output logic                Coef_w_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  loader_state_t state, state_n;

  logic [NTAPS*CW-1:0] shadow, shadow_n;
  logic                run_first, run_first_n;

  logic [NUMW-1:0] cnt;
  logic            tc;
  logic            cnt_clear;
  logic            cnt_en;
  logic            illegal;

  logic [DW-1:0]   fir_in_n;
  logic [NUMW-1:0] coef_num_n;
  logic [CW-1:0]   coef_val_n;
  logic            coef_w_en_n;
  logic            load_ack_n;
  logic            busy_n;
  logic            done_n;
  logic            err_n;

  zo_tap_counter #(
    .NUMW  (NUMW),
    .NTAPS (NTAPS)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (cnt_en),
    .count (cnt),
    .tc    (tc)
  );

`ifdef COEF_CHECK_EN
  // Scan the incoming word for the illegal code; only consulted on acceptance.
  always_comb begin
    illegal = 1'b0;
    for (int k = 0; k < NTAPS; k++) begin
      if (coef_bus[CW*k +: CW] == CW'(COEF_ILL)) begin
        illegal = 1'b1;
      end
    end
  end
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    shadow_n    = shadow;
    run_first_n = 1'b0;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    fir_in_n    = '0;
    coef_num_n  = '0;
    coef_val_n  = '0;
    coef_w_en_n = 1'b0;
    load_ack_n  = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    err_n       = 1'b0;

    unique case (state)
      IDLE: begin
        if (load_req) begin
          load_ack_n = 1'b1;
          if (illegal) begin
            err_n = 1'b1;
          end else begin
            shadow_n  = coef_bus;
            cnt_clear = 1'b1;
            state_n   = LOAD;
          end
        end
      end

      LOAD: begin
        coef_w_en_n = 1'b1;
        coef_num_n  = cnt;
        coef_val_n  = shadow[int'(cnt)*CW +: CW];
        busy_n      = 1'b1;
        cnt_en      = 1'b1;
        if (tc) begin
          cnt_clear = 1'b1;
          state_n   = FLUSH;
        end
      end

      FLUSH: begin
        busy_n = 1'b1;
        cnt_en = 1'b1;
        if (tc) begin
          cnt_clear   = 1'b1;
          run_first_n = 1'b1;
          state_n     = RUN;
        end
      end

      RUN: begin
        // The sample accepted alongside a new load still passes through;
        // zeros start once the FSM is in LOAD.
        fir_in_n = sample_in;
        done_n   = run_first;
        if (load_req) begin
          load_ack_n = 1'b1;
          if (illegal) begin
            err_n = 1'b1;
          end else begin
            shadow_n  = coef_bus;
            cnt_clear = 1'b1;
            state_n   = LOAD;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      run_first <= 1'b0;
      fir_in    <= '0;
      Coef_num  <= '0;
      Coef_Val  <= '0;
      Coef_w_en <= 1'b0;
      load_ack  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      shadow    <= shadow_n;
      run_first <= run_first_n;
      fir_in    <= fir_in_n;
      Coef_num  <= coef_num_n;
      Coef_Val  <= coef_val_n;
      Coef_w_en <= coef_w_en_n;
      load_ack  <= load_ack_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_fir_zo_coef_loader.sv
// Self-checking bench for fir_zo_coef_loader.
// A timeline model (cycles elapsed since the last accepted load) predicts
// every output on every cycle; directed sequences add literal expectations
// that pin the model to hand-computed values. Honours COEF_CHECK_EN.
module tb_fir_zo_coef_loader;

  localparam int NTAPS = 10;
  localparam int DW    = 8;
  localparam int CW    = 2;
  localparam int NUMW  = 4;
  localparam int VW    = 3 + NUMW + CW + 2 + DW;

`ifdef COEF_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic                load_req;
  logic [NTAPS*CW-1:0] coef_bus;
  logic [DW-1:0]       sample_in;
  logic                load_ack;
  logic [DW-1:0]       fir_in;
  logic [NUMW-1:0]     Coef_num;
  logic [CW-1:0]       Coef_Val;
  logic                Coef_w_en;
  logic                busy;
  logic                done;
  logic                err;

  int checks = 0;
  int errors = 0;

  fir_zo_coef_loader #(
    .NTAPS (NTAPS),
    .DW    (DW),
    .CW    (CW),
    .NUMW  (NUMW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_req  (load_req),
    .coef_bus  (coef_bus),
    .load_ack  (load_ack),
    .sample_in (sample_in),
    .fir_in    (fir_in),
    .Coef_num  (Coef_num),
    .Coef_Val  (Coef_Val),
    .Coef_w_en (Coef_w_en),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [VW-1:0] act_vec;
  assign act_vec = {load_ack, err, Coef_w_en, Coef_num, Coef_Val, busy, done, fir_in};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic lr, input logic [NTAPS*CW-1:0] cb,
                               input logic [DW-1:0] si);
    rst       = r;
    load_req  = lr;
    coef_bus  = cb;
    sample_in = si;
    @(posedge clk);
    #1;
  endtask

  function automatic bit has_illegal(input logic [NTAPS*CW-1:0] w);
    for (int k = 0; k < NTAPS; k++) begin
      if (w[CW*k +: CW] == 2'b10) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Timeline model: after a load is accepted at offset 0, offsets 1..NTAPS
  // write tap (offset-1), offsets NTAPS+1..2*NTAPS flush, and from offset
  // 2*NTAPS+1 the loader runs, with done on that first offset.
  bit                  model_valid = 1'b0;
  bit                  seq_active  = 1'b0;
  int                  since       = 0;
  logic [NTAPS*CW-1:0] m_word      = '0;
  logic [VW-1:0]       exp_vec     = '0;

  always @(posedge clk) begin
    logic            e_ack, e_err, e_wen, e_busy, e_done, can_accept;
    logic [NUMW-1:0] e_num;
    logic [CW-1:0]   e_val;
    logic [DW-1:0]   e_fir;
    e_ack = 0; e_err = 0; e_wen = 0; e_busy = 0; e_done = 0;
    e_num = '0; e_val = '0; e_fir = '0;
    if (rst) begin
      seq_active = 1'b0;
      since      = 0;
    end else begin
      can_accept = !seq_active;
      if (seq_active) begin
        if (since < 2*NTAPS + 2) since++;
        if (since <= NTAPS) begin
          e_wen  = 1'b1;
          e_num  = NUMW'(since - 1);
          e_val  = m_word[(since-1)*CW +: CW];
          e_busy = 1'b1;
        end else if (since <= 2*NTAPS) begin
          e_busy = 1'b1;
        end else begin
          e_fir      = sample_in;
          e_done     = (since == 2*NTAPS + 1);
          can_accept = 1'b1;
        end
      end
      if (can_accept && load_req) begin
        e_ack = 1'b1;
        if (CHECK_EN && has_illegal(coef_bus)) begin
          e_err = 1'b1;
        end else begin
          m_word     = coef_bus;
          seq_active = 1'b1;
          since      = 0;
        end
      end
    end
    exp_vec     = {e_ack, e_err, e_wen, e_num, e_val, e_busy, e_done, e_fir};
    model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) checkOutput("model_outputs", 32'(act_vec), 32'(exp_vec));
  end

  logic [CW-1:0]   std_vals [NTAPS] = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01};
  logic [CW-1:0]   seen_val [NTAPS];
  logic [NUMW-1:0] seen_num [NTAPS];
  int              busy_cnt, ack_cnt, wen_cnt, fir_nz, zero_cnt;
  logic [6:0]      imp_seq;

  initial begin
    rst = 1'b1; load_req = 1'b0; coef_bus = '0; sample_in = '0;

    // Reset state
    applyStimulus(1, 0, '0, 8'h00);
    applyStimulus(1, 0, '0, 8'h00);
    checkOutput("reset_state", 32'(act_vec), 32'd0);
    applyStimulus(0, 0, '0, 8'h55);
    checkOutput("idle_fir_zero", 32'(fir_in), 32'd0);

    // Standard load with an ignored request at k = 3
    applyStimulus(0, 1, 20'h4D34D, 8'h55);
    checkOutput("std_ack", {29'd0, load_ack, busy, Coef_w_en}, 32'b100);
    busy_cnt = 0; ack_cnt = 0; wen_cnt = 0; fir_nz = 0;
    for (int i = 0; i < 2*NTAPS; i++) begin
      applyStimulus(0, (i == 3), (i == 3) ? 20'hFFFFF : 20'h4D34D, 8'h55);
      busy_cnt += int'(busy);
      ack_cnt  += int'(load_ack);
      if (i < NTAPS) begin
        seen_val[i] = Coef_Val;
        seen_num[i] = Coef_num;
        wen_cnt += int'(Coef_w_en);
      end else if (fir_in != 0) begin
        fir_nz++;
      end
    end
    checkOutput("std_busy_cycles", 32'(busy_cnt), 32'd20);
    checkOutput("std_ignored_ack", 32'(ack_cnt), 32'd0);
    checkOutput("std_write_count", 32'(wen_cnt), 32'd10);
    checkOutput("flush_fir_zero", 32'(fir_nz), 32'd0);
    for (int k = 0; k < NTAPS; k++) begin
      checkOutput("std_val", 32'(seen_val[k]), 32'(std_vals[k]));
      checkOutput("std_num", 32'(seen_num[k]), 32'(k));
    end
    applyStimulus(0, 0, '0, 8'h00);
    checkOutput("std_done", {30'd0, done, busy}, 32'b10);

    // Impulse pass-through
    applyStimulus(0, 0, '0, 8'h01);
    imp_seq[6] = (fir_in == 8'h01);
    for (int i = 5; i >= 0; i--) begin
      applyStimulus(0, 0, '0, 8'h00);
      imp_seq[i] = (fir_in == 8'h01);
    end
    checkOutput("impulse", 32'(imp_seq), 32'b1000000);

    // Reload from RUN with a streaming 0xFF
    applyStimulus(0, 0, '0, 8'hFF);
    applyStimulus(0, 0, '0, 8'hFF);
    checkOutput("run_stream", 32'(fir_in), 32'hFF);
    applyStimulus(0, 1, 20'h4D34D, 8'hFF);
    checkOutput("reload_ack", {23'd0, load_ack, fir_in}, {23'd0, 1'b1, 8'hFF});
    zero_cnt = 0;
    for (int i = 0; i < 2*NTAPS; i++) begin
      applyStimulus(0, 0, 20'h4D34D, 8'hFF);
      if (fir_in == 8'h00) zero_cnt++;
    end
    checkOutput("reload_zero_cycles", 32'(zero_cnt), 32'd20);
    applyStimulus(0, 0, 20'h4D34D, 8'hFF);
    checkOutput("reload_resume", {23'd0, done, fir_in}, {23'd0, 1'b1, 8'hFF});

    // Reset in the middle of LOAD
    applyStimulus(0, 1, 20'h0F0F0, 8'h00);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 20'h0F0F0, 8'h00);
    checkOutput("midload_k5", {27'd0, Coef_w_en, Coef_num}, {27'd0, 1'b1, 4'd5});
    applyStimulus(1, 0, 20'h0F0F0, 8'h00);
    checkOutput("midload_reset", 32'(act_vec), 32'd0);
    applyStimulus(0, 1, 20'hF0F0F, 8'h00);
    applyStimulus(0, 0, 20'hF0F0F, 8'h00);
    checkOutput("restart_first_write", {25'd0, Coef_w_en, Coef_num, Coef_Val}, {25'd0, 1'b1, 4'd0, 2'b11});
    for (int i = 0; i < 25; i++) applyStimulus(0, 0, 20'hF0F0F, 8'h00);

    // Word with illegal code 10 at tap 4, offered from RUN
    applyStimulus(0, 1, 20'h4D24D, 8'h33);
`ifdef COEF_CHECK_EN
    checkOutput("illegal_ack_err", {21'd0, load_ack, err, busy, fir_in}, {21'd0, 3'b110, 8'h33});
    applyStimulus(0, 0, 20'h4D24D, 8'h33);
    checkOutput("illegal_no_write", {22'd0, Coef_w_en, busy, fir_in}, {22'd0, 2'b00, 8'h33});
`else
    checkOutput("illegal_ack_noerr", {30'd0, load_ack, err}, 32'b10);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 20'h4D24D, 8'h33);
    checkOutput("illegal_written", {26'd0, Coef_num, Coef_Val}, {26'd0, 4'd4, 2'b10});
`endif

    // load_req held continuously: done and the next ack coincide
    applyStimulus(1, 0, '0, 8'h00);
    for (int i = 0; i < 2*NTAPS + 2; i++) applyStimulus(0, 1, 20'h4D34D, 8'h11);
    checkOutput("held_req_done_ack", {30'd0, done, load_ack}, 32'b11);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 11) == 0),
                    ($urandom_range(0, 1) == 0) ? 20'($urandom) : 20'($urandom) & 20'h55555,
                    8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
